// File: rtl/flash_rom_sequencer.sv
// Eco32 ROM-slot controller for a 16-bit parallel flash: issues the power-up reset
// pulse, splits bus reads into timed halfword accesses and stalls the bus until done.
module flash_rom_sequencer #(
  parameter int unsigned ACCESS_CYCLES   = 7,
  parameter int unsigned RESET_CYCLES    = 50,
  parameter int unsigned RECOVERY_CYCLES = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        busEnable,
  input  logic        busWrite,
  input  logic [1:0]  busAccessSize,
  input  logic [20:0] busAddress,
  input  logic [31:0] busWriteData,
  output logic [31:0] busReadData,
  output logic        busWait,
  output logic        romChipEnableInverted,
  output logic        romOutputEnableInverted,
  output logic        romWriteEnableInverted,
  output logic        romResetInverted,
  output logic        romByteInverted,
  output logic [19:0] romAddress,
  input  logic [15:0] romData
);

  localparam int unsigned MAX_AR     = (ACCESS_CYCLES > RESET_CYCLES) ? ACCESS_CYCLES : RESET_CYCLES;
  localparam int unsigned MAX_CYCLES = (MAX_AR > RECOVERY_CYCLES) ? MAX_AR : RECOVERY_CYCLES;
  localparam int unsigned CW         = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

  // Zero-length phases collapse to a single cycle rather than underflowing the counter.
  localparam int unsigned ACC_LOAD = (ACCESS_CYCLES   > 0) ? ACCESS_CYCLES   - 1 : 0;
  localparam int unsigned RST_LOAD = (RESET_CYCLES    > 0) ? RESET_CYCLES    - 1 : 0;
  localparam int unsigned REC_LOAD = (RECOVERY_CYCLES > 0) ? RECOVERY_CYCLES - 1 : 0;

  typedef enum logic [2:0] {
    ST_RESET_PULSE,
    ST_RECOVER,
    ST_IDLE,
    ST_ACCESS_HI,
    ST_ACCESS_LO,
    ST_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [20:0]   addr_q, addr_d;
  logic [1:0]    size_q, size_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          is_word;
  logic          unused_write_data;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_RESET_PULSE;
      cnt_q   <= CW'(RST_LOAD);
      addr_q  <= '0;
      size_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    size_d  = size_q;
    rdata_d = rdata_q;
    is_word = size_q[1];

    case (state_q)
      ST_RESET_PULSE: begin
        if (cnt_q == '0) begin
          state_d = ST_RECOVER;
          cnt_d   = CW'(REC_LOAD);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_RECOVER: begin
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ST_IDLE: begin
        if (busEnable && !busWrite) begin
          addr_d  = busAddress;
          size_d  = busAccessSize;
          cnt_d   = CW'(ACC_LOAD);
          state_d = ST_ACCESS_HI;
        end
      end
      ST_ACCESS_HI: begin
        if (cnt_q == '0) begin
          if (is_word) begin
            rdata_d = {romData, 16'h0000};
            cnt_d   = CW'(ACC_LOAD);
            state_d = ST_ACCESS_LO;
          end else begin
            if (size_q[0]) rdata_d = {16'h0000, romData};
            else           rdata_d = {24'h000000, addr_q[0] ? romData[7:0] : romData[15:8]};
            state_d = ST_DONE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_ACCESS_LO: begin
        if (cnt_q == '0) begin
          rdata_d = {rdata_q[31:16], romData};
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_RESET_PULSE;
    endcase
  end

  always_comb begin
    romAddress = '0;
    case (state_q)
      ST_ACCESS_HI: romAddress = size_q[1] ? {addr_q[20:2], 1'b0} : addr_q[20:1];
      ST_ACCESS_LO: romAddress = {addr_q[20:2], 1'b1};
      default:      romAddress = '0;
    endcase
    romChipEnableInverted   = !((state_q == ST_ACCESS_HI) || (state_q == ST_ACCESS_LO));
    romOutputEnableInverted = !((state_q == ST_ACCESS_HI) || (state_q == ST_ACCESS_LO));
    romWriteEnableInverted  = 1'b1;
    romByteInverted         = 1'b1;
    romResetInverted        = (state_q != ST_RESET_PULSE);
    busReadData             = rdata_q;
    // Writes complete immediately from IDLE; every other non-DONE state stalls.
    busWait = busEnable && !((state_q == ST_DONE) || ((state_q == ST_IDLE) && busWrite));
    unused_write_data = ^busWriteData;
  end

endmodule

// File: tb/tb_flash_rom_sequencer.sv
// Randomized self-checking bench for flash_rom_sequencer against a flash/latency model.
module tb_flash_rom_sequencer;

  localparam int unsigned N      = 7;
  localparam int unsigned RST_N  = 50;
  localparam int unsigned RECOV  = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        en, wr;
  logic [1:0]  sz;
  logic [20:0] addr;
  logic [31:0] wdata, rdata;
  logic        bw, ce_n, oe_n, we_n, rst_n, byte_n;
  logic [19:0] raddr;
  logic [15:0] rom_dq;

  logic        b_en, b_wr;
  logic [1:0]  b_sz;
  logic [20:0] b_addr;
  logic [31:0] b_wdata, b_rdata;
  logic        b_bw, b_ce_n, b_oe_n, b_we_n, b_rst_n, b_byte_n;
  logic [19:0] b_raddr;
  logic [15:0] b_rom_dq;

  int checks = 0;
  int fails  = 0;

  always #5 clock = ~clock;

  function automatic logic [15:0] flash_val(input logic [19:0] a);
    if (a == 20'h00082) return 16'h1234;
    if (a == 20'h00083) return 16'hABCD;
    return (a[15:0] * 16'h9E37) ^ {a[19:16], a[11:0]};
  endfunction

  function automatic logic [31:0] exp_read(input logic [20:0] a, input logic [1:0] s);
    logic [15:0] h;
    h = flash_val(a[20:1]);
    if (s[1]) return {flash_val({a[20:2], 1'b0}), flash_val({a[20:2], 1'b1})};
    if (s[0]) return {16'h0000, h};
    return {24'h000000, a[0] ? h[7:0] : h[15:8]};
  endfunction

  assign rom_dq   = (!ce_n && !oe_n) ? flash_val(raddr) : 16'hDEAD;
  assign b_rom_dq = (!b_ce_n && !b_oe_n) ? flash_val(b_raddr) : 16'hDEAD;

  flash_rom_sequencer #(.ACCESS_CYCLES(N), .RESET_CYCLES(RST_N), .RECOVERY_CYCLES(RECOV)) dut (
    .clock(clock), .reset(reset), .busEnable(en), .busWrite(wr), .busAccessSize(sz),
    .busAddress(addr), .busWriteData(wdata), .busReadData(rdata), .busWait(bw),
    .romChipEnableInverted(ce_n), .romOutputEnableInverted(oe_n),
    .romWriteEnableInverted(we_n), .romResetInverted(rst_n), .romByteInverted(byte_n),
    .romAddress(raddr), .romData(rom_dq)
  );

  flash_rom_sequencer #(.ACCESS_CYCLES(1), .RESET_CYCLES(3), .RECOVERY_CYCLES(2)) dut_fast (
    .clock(clock), .reset(reset), .busEnable(b_en), .busWrite(b_wr), .busAccessSize(b_sz),
    .busAddress(b_addr), .busWriteData(b_wdata), .busReadData(b_rdata), .busWait(b_bw),
    .romChipEnableInverted(b_ce_n), .romOutputEnableInverted(b_oe_n),
    .romWriteEnableInverted(b_we_n), .romResetInverted(b_rst_n), .romByteInverted(b_byte_n),
    .romAddress(b_raddr), .romData(b_rom_dq)
  );

  // Entered at #1 after a posedge with state IDLE; leaves at #1 after the edge out of DONE.
  task automatic do_read(input string name, input logic [20:0] a, input logic [1:0] s);
    int unsigned k;
    int unsigned done_at;
    bit          got;
    logic [19:0] hi, lo;
    k = 0; got = 0;
    done_at = s[1] ? 2 * N + 1 : N + 1;
    hi = s[1] ? {a[20:2], 1'b0} : a[20:1];
    lo = {a[20:2], 1'b1};
    en = 1'b1; wr = 1'b0; sz = s; addr = a; wdata = $urandom;
    while (k <= 4 * N + 4 && !got) begin
      @(negedge clock);
      if (k >= 1 && k <= N) begin
        checks++;
        if (raddr !== hi || ce_n !== 1'b0 || oe_n !== 1'b0) begin
          fails++;
          $display("FAIL %s_hi_addr cycle %0d: romAddress=%h ce_n=%b oe_n=%b, required %h 0 0", name, k, raddr, ce_n, oe_n, hi);
        end
      end else if (s[1] && k > N && k <= 2 * N) begin
        checks++;
        if (raddr !== lo || ce_n !== 1'b0 || oe_n !== 1'b0) begin
          fails++;
          $display("FAIL %s_lo_addr cycle %0d: romAddress=%h ce_n=%b oe_n=%b, required %h 0 0", name, k, raddr, ce_n, oe_n, lo);
        end
      end
      if (bw === 1'b0) got = 1;
      else begin
        @(posedge clock); #1;
        k++;
      end
    end
    checks++;
    if (!got || k != done_at) begin
      fails++;
      $display("FAIL %s_latency: done at cycle %0d (seen=%0d), required %0d", name, k, got, done_at);
    end
    checks++;
    if (rdata !== exp_read(a, s)) begin
      fails++;
      $display("FAIL %s_data: busReadData=%h, required %h", name, rdata, exp_read(a, s));
    end
    @(posedge clock); #1;
    en = 1'b0;
  endtask

  // Reset just released with a word read pending: check pulse length, recovery and the read.
  task automatic release_and_read(input string name, input logic [20:0] a);
    int unsigned lows;
    int unsigned k;
    lows = 0;
    while (lows < 200) begin
      @(negedge clock);
      if (rst_n !== 1'b0) break;
      lows++;
      checks++;
      if (bw !== 1'b1) begin
        fails++;
        $display("FAIL %s_pulse_wait: busWait=%b, required 1", name, bw);
      end
    end
    checks++;
    if (lows != RST_N) begin
      fails++;
      $display("FAIL %s_pulse_len: romResetInverted low %0d cycles, required %0d", name, lows, RST_N);
    end
    k = 0;
    while (k < 100 && bw !== 1'b0) begin
      if (k <= RECOV) begin
        checks++;
        if (ce_n !== 1'b1) begin
          fails++;
          $display("FAIL %s_recover_ce: ce_n=%b at cycle %0d after release, required 1", name, ce_n, k);
        end
      end
      @(negedge clock);
      k++;
    end
    checks++;
    if (k != RECOV + 2 * N + 1) begin
      fails++;
      $display("FAIL %s_recover_latency: done %0d cycles after release, required %0d", name, k, RECOV + 2 * N + 1);
    end
    checks++;
    if (rdata !== exp_read(a, 2'd2)) begin
      fails++;
      $display("FAIL %s_data: busReadData=%h, required %h", name, rdata, exp_read(a, 2'd2));
    end
    @(posedge clock); #1;
    en = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clock);
    checks++;
    if (rst_n !== 1'b0 || ce_n !== 1'b1 || oe_n !== 1'b1 || we_n !== 1'b1 || byte_n !== 1'b1) begin
      fails++;
      $display("FAIL reset_ctrl: rst_n=%b ce_n=%b oe_n=%b we_n=%b byte_n=%b, required 0 1 1 1 1", rst_n, ce_n, oe_n, we_n, byte_n);
    end
    checks++;
    if (raddr !== 20'h0 || rdata !== 32'h0 || bw !== 1'b0) begin
      fails++;
      $display("FAIL reset_values: romAddress=%h busReadData=%h busWait=%b, required 0 0 0", raddr, rdata, bw);
    end
    @(posedge clock); #1;
    en = 1'b1; wr = 1'b1;
    @(negedge clock);
    checks++;
    if (bw !== 1'b1) begin
      fails++;
      $display("FAIL reset_write_wait: busWait=%b, required 1", bw);
    end
    @(posedge clock); #1;
    wr = 1'b0; sz = 2'd2; addr = 21'h000104; reset = 1'b0;
    release_and_read("reset", 21'h000104);
  endtask

  task automatic test_directed_reads();
    do_read("word_104", 21'h000104, 2'd2);
    do_read("byte_105", 21'h000105, 2'd0);
    do_read("byte_104", 21'h000104, 2'd0);
    do_read("half_104", 21'h000104, 2'd1);
    do_read("word_107", 21'h000107, 2'd3);
  endtask

  task automatic test_write();
    en = 1'b1; wr = 1'b1; sz = 2'd2; addr = 21'h000010; wdata = 32'hCAFEF00D;
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      checks++;
      if (bw !== 1'b0 || ce_n !== 1'b1 || oe_n !== 1'b1 || we_n !== 1'b1) begin
        fails++;
        $display("FAIL write_%0d: busWait=%b ce_n=%b oe_n=%b we_n=%b, required 0 1 1 1", i, bw, ce_n, oe_n, we_n);
      end
      @(posedge clock); #1;
    end
    en = 1'b0; wr = 1'b0;
  endtask

  task automatic test_random_reads();
    logic [31:0] r;
    for (int i = 0; i < 24; i++) begin
      r = $urandom;
      do_read("rand", r[20:0], 2'($urandom_range(0, 3)));
    end
  endtask

  task automatic test_enable_drop();
    logic [31:0] r;
    logic [19:0] lo;
    r = $urandom;
    lo = {r[20:2], 1'b1};
    en = 1'b1; wr = 1'b0; sz = 2'd2; addr = r[20:0];
    for (int unsigned k = 1; k <= 2 * N + 1; k++) begin
      @(posedge clock); #1;
      if (k == 3) en = 1'b0;
      @(negedge clock);
      if (k == 2 * N) begin
        checks++;
        if (ce_n !== 1'b0 || raddr !== lo) begin
          fails++;
          $display("FAIL drop_completes: ce_n=%b romAddress=%h, required 0 %h", ce_n, raddr, lo);
        end
      end
      if (k == 2 * N + 1) begin
        checks++;
        if (ce_n !== 1'b1) begin
          fails++;
          $display("FAIL drop_done: ce_n=%b, required 1", ce_n);
        end
      end
    end
    @(posedge clock); #1;
    r = $urandom;
    do_read("after_drop", r[20:0], 2'd1);
  endtask

  task automatic test_reset_mid();
    en = 1'b1; wr = 1'b0; sz = 2'd2; addr = 21'h000104;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock); #1;
    @(negedge clock);
    checks++;
    if (ce_n !== 1'b1 || oe_n !== 1'b1 || rst_n !== 1'b0 || bw !== 1'b1) begin
      fails++;
      $display("FAIL mid_reset: ce_n=%b oe_n=%b rst_n=%b busWait=%b, required 1 1 0 1", ce_n, oe_n, rst_n, bw);
    end
    @(posedge clock); #1;
    reset = 1'b0;
    release_and_read("mid_reset", 21'h000104);
  endtask

  task automatic test_back_to_back();
    logic [31:0] a1, a2;
    bit done_exp;
    a1 = $urandom; a2 = $urandom;
    b_en = 1'b1; b_wr = 1'b0; b_sz = 2'd2; b_addr = a1[20:0];
    for (int k = 0; k < 8; k++) begin
      if (k == 4) b_addr = a2[20:0];
      @(negedge clock);
      done_exp = ((k % 4) == 3);
      checks++;
      if (b_bw !== !done_exp) begin
        fails++;
        $display("FAIL b2b_wait cycle %0d: busWait=%b, required %b", k, b_bw, !done_exp);
      end
      if (done_exp) begin
        checks++;
        if (b_rdata !== exp_read(k < 4 ? a1[20:0] : a2[20:0], 2'd2)) begin
          fails++;
          $display("FAIL b2b_data cycle %0d: busReadData=%h, required %h", k, b_rdata, exp_read(k < 4 ? a1[20:0] : a2[20:0], 2'd2));
        end
      end
      @(posedge clock); #1;
    end
    b_en = 1'b0;
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; wr = 1'b0; sz = '0; addr = '0; wdata = '0;
    b_en = 1'b0; b_wr = 1'b0; b_sz = '0; b_addr = '0; b_wdata = '0;
    repeat (2) @(posedge clock);
    #1;
    test_reset();
    test_directed_reads();
    test_write();
    test_random_reads();
    test_enable_drop();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
